// File: rtl/cook_timer_pkg.sv
// Shared types and constants for the cook timer control slice.
package cook_timer_pkg;

  localparam int DIGIT_W   = 4;
  localparam int SEC_LIMIT = 59;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

endpackage

// File: rtl/cook_timer_ctrl_bcd_set_60.sv
// Two-digit BCD setting register: synchronous clear, +1 on inc, wraps LIMIT -> 00.
module bcd_set_60
  import cook_timer_pkg::*;
#(
  parameter int LIMIT = 59
) (
  input  logic               clk,
  input  logic               reset_p,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] tens
);

  localparam logic [DIGIT_W-1:0] LIM_ONES = DIGIT_W'(LIMIT % 10);
  localparam logic [DIGIT_W-1:0] LIM_TENS = DIGIT_W'(LIMIT / 10);

  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic [DIGIT_W-1:0] tens_q, tens_d;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = '0;
      tens_d = '0;
    end else if (inc) begin
      if (tens_q == LIM_TENS && ones_q == LIM_ONES) begin
        ones_d = '0;
        tens_d = '0;
      end else if (ones_q == DIGIT_W'(9)) begin
        ones_d = '0;
        tens_d = tens_q + DIGIT_W'(1);
      end else begin
        ones_d = ones_q + DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;

endmodule

// File: rtl/cook_timer_ctrl.sv
// Cook timer control: holds the mm:ss setting, gates the 1 s tick, raises alarm at 00:00.
// Optional macro ALARM_TIMEOUT_EN: alarm self-clears after ALARM_SEC ticks.
module cook_timer_ctrl
  import cook_timer_pkg::*;
#(
  parameter int MIN_LIMIT = 59,
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       btn_start,
  input  logic       btn_inc_min,
  input  logic       btn_inc_sec,
  input  logic       btn_clear,
  input  logic       clk_sec,
  input  logic [3:0] cnt_sec1,
  input  logic [3:0] cnt_sec10,
  input  logic [3:0] cnt_min1,
  input  logic [3:0] cnt_min10,
  output logic       load_enable,
  output logic [3:0] set_sec1,
  output logic [3:0] set_sec10,
  output logic [3:0] set_min1,
  output logic [3:0] set_min10,
  output logic       clk_time,
  output logic       alarm,
  output logic [1:0] state_o
);

  state_t state_q, state_d;
  logic   clk_time_q, clk_time_d;
  logic   alarm_q, alarm_d;

  // Only the highest-priority pulse in a cycle acts.
  logic act_clr, act_start, act_min, act_sec, any_btn;
  assign act_clr   = btn_clear;
  assign act_start = btn_start & ~btn_clear;
  assign act_min   = btn_inc_min & ~btn_start & ~btn_clear;
  assign act_sec   = btn_inc_sec & ~btn_inc_min & ~btn_start & ~btn_clear;
  assign any_btn   = btn_clear | btn_start | btn_inc_min | btn_inc_sec;

  logic in_set;
  assign in_set = (state_q == ST_SET);

  bcd_set_60 #(.LIMIT(SEC_LIMIT)) u_sec (
    .clk    (clk),
    .reset_p(reset_p),
    .clr    (in_set & act_clr),
    .inc    (in_set & act_sec),
    .ones   (set_sec1),
    .tens   (set_sec10)
  );

  bcd_set_60 #(.LIMIT(MIN_LIMIT)) u_min (
    .clk    (clk),
    .reset_p(reset_p),
    .clr    (in_set & act_clr),
    .inc    (in_set & act_min),
    .ones   (set_min1),
    .tens   (set_min10)
  );

  logic set_nonzero, cnt_zero;
  assign set_nonzero = |{set_sec1, set_sec10, set_min1, set_min10};
  assign cnt_zero    = ~|{cnt_sec1, cnt_sec10, cnt_min1, cnt_min10};

  logic timeout;
`ifdef ALARM_TIMEOUT_EN
  localparam int TO_W = $clog2(ALARM_SEC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != ST_ALARM)
      to_cnt_d = '0;
    else if (clk_sec)
      to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset_p) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end

  assign timeout = (state_q == ST_ALARM) && clk_sec && (to_cnt_q == TO_W'(ALARM_SEC - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register plus the two registered outputs.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q    <= ST_SET;
      clk_time_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_time_q <= clk_time_d;
      alarm_q    <= alarm_d;
    end
  end

  // Zero detect waits while a tick is in flight so the counters see it first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SET:   if (act_start && set_nonzero) state_d = ST_RUN;
      ST_RUN: begin
        if (act_clr)                      state_d = ST_SET;
        else if (act_start)               state_d = ST_PAUSE;
        else if (cnt_zero && !clk_time_q) state_d = ST_ALARM;
      end
      ST_PAUSE: begin
        if (act_clr)        state_d = ST_SET;
        else if (act_start) state_d = ST_RUN;
      end
      ST_ALARM: if (any_btn || timeout) state_d = ST_SET;
      default:  state_d = ST_SET;
    endcase
  end

  always_comb begin
    load_enable = (state_q == ST_SET);
    clk_time_d  = clk_sec && (state_q == ST_RUN);
    alarm_d     = (state_d == ST_ALARM);
  end

  assign clk_time = clk_time_q;
  assign alarm    = alarm_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed self-checking bench for cook_timer_ctrl.
module tb_cook_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       btn_start = 0, btn_inc_min = 0, btn_inc_sec = 0, btn_clear = 0;
  logic       clk_sec = 0;
  logic [3:0] cnt_sec1 = 0, cnt_sec10 = 0, cnt_min1 = 0, cnt_min10 = 0;
  logic       load_enable, clk_time, alarm;
  logic [3:0] set_sec1, set_sec10, set_min1, set_min10;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  cook_timer_ctrl dut (
    .clk(clk), .reset_p(reset_p),
    .btn_start(btn_start), .btn_inc_min(btn_inc_min),
    .btn_inc_sec(btn_inc_sec), .btn_clear(btn_clear),
    .clk_sec(clk_sec),
    .cnt_sec1(cnt_sec1), .cnt_sec10(cnt_sec10),
    .cnt_min1(cnt_min1), .cnt_min10(cnt_min10),
    .load_enable(load_enable),
    .set_sec1(set_sec1), .set_sec10(set_sec10),
    .set_min1(set_min1), .set_min10(set_min10),
    .clk_time(clk_time), .alarm(alarm), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_set(input string tag, input logic [15:0] exp);
    chk(tag, {set_min10, set_min1, set_sec10, set_sec1}, exp);
  endtask

  task automatic press(input int which);
    case (which)
      0: btn_clear = 1;
      1: btn_start = 1;
      2: btn_inc_min = 1;
      default: btn_inc_sec = 1;
    endcase
    tick();
    {btn_clear, btn_start, btn_inc_min, btn_inc_sec} = '0;
  endtask

  task automatic sec_tick();
    clk_sec = 1;
    tick();
    clk_sec = 0;
  endtask

  task automatic set_cnt(input logic [15:0] v);
    {cnt_min10, cnt_min1, cnt_sec10, cnt_sec1} = v;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_state", 16'(state_o), 16'd0);
    chk("rst_load", 16'(load_enable), 16'd1);
    chk("rst_clk_time", 16'(clk_time), 16'd0);
    chk("rst_alarm", 16'(alarm), 16'd0);
    chk_set("rst_set", 16'h0000);
    reset_p = 0;

    // 3 x inc_min, 5 x inc_sec -> 03:05
    for (int i = 0; i < 3; i++) press(2);
    for (int i = 0; i < 5; i++) press(3);
    chk_set("set_0305", 16'h0305);
    chk("set_load", 16'(load_enable), 16'd1);
    chk("set_state", 16'(state_o), 16'd0);

    // Seconds wrap 59 -> 00 without touching minutes
    press(0);
    chk_set("clear", 16'h0000);
    for (int i = 0; i < 3; i++) press(2);
    for (int i = 0; i < 59; i++) press(3);
    chk_set("sec_59", 16'h0359);
    press(3);
    chk_set("sec_wrap", 16'h0300);

    // Start with 00:00 is ignored
    press(0);
    press(1);
    chk("start_zero", 16'(state_o), 16'd0);

    // 00:02, start -> RUN
    press(3); press(3);
    chk_set("set_0002", 16'h0002);
    set_cnt(16'h0002);
    press(1);
    chk("run_state", 16'(state_o), 16'd1);
    chk("run_load", 16'(load_enable), 16'd0);
    chk("run_no_tick", 16'(clk_time), 16'd0);
    sec_tick();
    chk("run_tick", 16'(clk_time), 16'd1);
    tick();
    chk("run_tick_width", 16'(clk_time), 16'd0);

    // inc ignored in RUN
    press(2);
    chk_set("run_inc_ignored", 16'h0002);

    // PAUSE loses ticks
    press(1);
    chk("pause_state", 16'(state_o), 16'd2);
    for (int i = 0; i < 3; i++) begin
      sec_tick();
      chk("pause_no_tick", 16'(clk_time), 16'd0);
    end
    press(1);
    chk("resume_state", 16'(state_o), 16'd1);
    sec_tick();
    chk("resume_tick", 16'(clk_time), 16'd1);

    // Zero seen while a tick is still high: no alarm yet, then alarm
    set_cnt(16'h0000);
    tick();
    chk("zero_held_off", 16'(state_o), 16'd1);
    chk("zero_held_alarm", 16'(alarm), 16'd0);
    tick();
    chk("alarm_state", 16'(state_o), 16'd3);
    chk("alarm_on", 16'(alarm), 16'd1);
    chk("alarm_load", 16'(load_enable), 16'd0);

`ifdef ALARM_TIMEOUT_EN
    for (int i = 0; i < 9; i++) begin
      sec_tick();
      tick();
    end
    chk("alarm_before_timeout", 16'(alarm), 16'd1);
    sec_tick();
    chk("timeout_alarm", 16'(alarm), 16'd0);
    chk("timeout_state", 16'(state_o), 16'd0);
`else
    for (int i = 0; i < 20; i++) begin
      sec_tick();
      chk("alarm_no_tick", 16'(clk_time), 16'd0);
      tick();
    end
    chk("alarm_persist", 16'(alarm), 16'd1);
    press(0);
    chk("alarm_exit_state", 16'(state_o), 16'd0);
    chk("alarm_exit_alarm", 16'(alarm), 16'd0);
`endif
    chk_set("alarm_retained", 16'h0002);

    // clear + start in RUN: clear wins, setting retained
    set_cnt(16'h0002);
    press(1);
    chk("run2_state", 16'(state_o), 16'd1);
    btn_clear = 1; btn_start = 1;
    tick();
    btn_clear = 0; btn_start = 0;
    chk("clr_wins_state", 16'(state_o), 16'd0);
    chk("clr_wins_load", 16'(load_enable), 16'd1);
    chk_set("clr_wins_set", 16'h0002);

    // Alarm exit via inc_min; inc has no effect on setting
    press(1);
    set_cnt(16'h0000);
    tick();
    chk("alarm2_on", 16'(alarm), 16'd1);
    press(2);
    chk("btn_exit_state", 16'(state_o), 16'd0);
    chk("btn_exit_alarm", 16'(alarm), 16'd0);
    chk_set("btn_exit_set", 16'h0002);

    // Reset in the middle of ALARM
    set_cnt(16'h0002);
    press(1);
    set_cnt(16'h0000);
    tick();
    chk("alarm3_on", 16'(alarm), 16'd1);
    reset_p = 1;
    tick();
    chk("rst_alarm_off", 16'(alarm), 16'd0);
    chk("rst_alarm_state", 16'(state_o), 16'd0);
    chk_set("rst_alarm_set", 16'h0000);
    reset_p = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
